// File: rtl/score_pkg.sv
// Shared types and constants for the bird-game score path.
// Used by score_keeper and its pass-edge sub-module.
package score_pkg;

  // Game phase as tracked by the score keeper.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAYING,
    ST_OVER
  } game_state_t;

  // Internal score counter width; two decimal digits fit in 7 bits.
  localparam int SCORE_W = 7;

  // Default saturation ceiling; the two-digit HEX display tops out at 99.
  localparam int MAX_SCORE_DEFAULT = 99;

  // Default number of clocks to ignore further passes after a counted one.
  localparam int COOLDOWN_DEFAULT = 16;

endpackage : score_pkg

// File: rtl/pass_edge_detect.sv
// Rising-edge detector for a level input: one history flop, and a single-clock
// pulse while the level is high and was low on the previous clock.
// Shared by several game inputs (pipe pass, flap button).
module pass_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  // History flop: remembers the level seen on the previous clock.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    if (reset) r_level_q <= 1'b0;
    else       r_level_q <= i_level;
  end

  assign o_rise = i_level & ~r_level_q;

endmodule : pass_edge_detect

// File: rtl/score_keeper.sv
// Game-phase FSM and saturating pipe-pass score counter that feeds the HEX
// score display. Optional best-score register is built when the macro
// SCORE_HIGH_EN is defined; without it the high_score port does not exist.
module score_keeper
  import score_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEFAULT,
  parameter int COOLDOWN  = COOLDOWN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pipe_pass,
  input  logic        collision,
  output logic [31:0] score,
  output logic        playing,
  output logic        game_over,
  output logic        score_event
`ifdef SCORE_HIGH_EN
  ,
  output logic [31:0] high_score
`endif
);

  localparam int                 CD_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN - 1);
  localparam logic [SCORE_W-1:0] SAT_MAX = SCORE_W'(MAX_SCORE);

  game_state_t        r_state;
  game_state_t        w_state_next;
  logic [SCORE_W-1:0] r_score;
  logic [CD_W-1:0]    r_cool;
  logic               r_inc;
  logic               r_event;
  logic               r_playing;
  logic               r_game_over;
  logic               w_rise;
  logic               w_count;
  logic               w_inc;

  pass_edge_detect u_pass_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (pipe_pass),
    .o_rise  (w_rise)
  );

  // A pass counts only while playing, without a simultaneous hit, outside cooldown.
  assign w_count = w_rise && (r_state == ST_PLAYING) && !collision && (r_cool == '0);
  // At saturation the pass is still consumed (cooldown reloads) but the score holds.
  assign w_inc   = w_count && (r_score < SAT_MAX);

  // Next-state logic: start is only honoured outside PLAYING, collision only inside.
  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (start)     w_state_next = ST_PLAYING;
      ST_PLAYING: if (collision) w_state_next = ST_OVER;
      ST_OVER:    if (start)     w_state_next = ST_IDLE;
      default:                   w_state_next = ST_IDLE;
    endcase
  end

  // State register plus registered phase flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_playing   <= (w_state_next == ST_PLAYING);
      r_game_over <= (w_state_next == ST_OVER);
    end
  end

  // Score: cleared when a game starts, saturating increment on counted passes.
  always_ff @(posedge clk) begin
    if (reset)                              r_score <= '0;
    else if ((r_state == ST_IDLE) && start) r_score <= '0;
    else if (w_inc)                         r_score <= r_score + 1'b1;
  end

  // Cooldown: reload on every counted pass, then count down to zero.
  always_ff @(posedge clk) begin
    if (reset)              r_cool <= '0;
    else if (w_count)       r_cool <= CD_LOAD;
    else if (r_cool != '0)  r_cool <= r_cool - 1'b1;
  end

  // Event pipeline: pulse one clock after the score register has changed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inc   <= 1'b0;
      r_event <= 1'b0;
    end else begin
      r_inc   <= w_inc;
      r_event <= r_inc;
    end
  end

  assign score       = 32'(r_score);
  assign playing     = r_playing;
  assign game_over   = r_game_over;
  assign score_event = r_event;

`ifdef SCORE_HIGH_EN
  logic [SCORE_W-1:0] r_high;

  // Best score: captured on the PLAYING->OVER edge, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_high <= '0;
    end else if ((r_state == ST_PLAYING) && (w_state_next == ST_OVER) && (r_score > r_high)) begin
      r_high <= r_score;
    end
  end

  assign high_score = 32'(r_high);
`endif

endmodule : score_keeper

// File: tb/tb_score_keeper.sv
// Directed testbench for score_keeper (COOLDOWN=4, MAX_SCORE=99).
// The best-score scenario is exercised when SCORE_HIGH_EN is defined.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pipe_pass;
  logic        collision;
  logic [31:0] score;
  logic        playing;
  logic        game_over;
  logic        score_event;
`ifdef SCORE_HIGH_EN
  logic [31:0] high_score;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ev_count = 0;
  int ev_snap;

  score_keeper #(.MAX_SCORE(99), .COOLDOWN(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pipe_pass   (pipe_pass),
    .collision   (collision),
    .score       (score),
    .playing     (playing),
    .game_over   (game_over),
    .score_event (score_event)
`ifdef SCORE_HIGH_EN
    ,
    .high_score  (high_score)
`endif
  );

  always #5 clk = ~clk;

  // Count every clock on which score_event is high.
  always @(posedge clk) if (score_event === 1'b1) ev_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic end_game();
    collision = 1'b1;
    step();
    collision = 1'b0;
  endtask

  // n passes, each 1 clk high then 5 clks low (clear of a 4-clk cooldown).
  task automatic do_passes(input int n);
    for (int i = 0; i < n; i++) begin
      pipe_pass = 1'b1;
      step();
      pipe_pass = 1'b0;
      repeat (5) step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pipe_pass = 1'b0; collision = 1'b0;
    #1;
    repeat (2) step();
    reset = 1'b0;

    // 1. Reset state, then three long separated passes with exact event timing.
    check("rst_score",     score,       32'd0);
    check("rst_playing",   playing,     32'd0);
    check("rst_game_over", game_over,   32'd0);
    check("rst_event",     score_event, 32'd0);
    pulse_start();
    check("t1_playing", playing, 32'd1);
    check("t1_score0",  score,   32'd0);
    ev_snap = ev_count;
    for (int k = 1; k <= 3; k++) begin
      pipe_pass = 1'b1;
      step();
      check("t1_score_n1", score,       32'(k));
      check("t1_ev_n1",    score_event, 32'd0);
      step();
      check("t1_ev_n2",    score_event, 32'd1);
      step();
      check("t1_ev_n3",    score_event, 32'd0);
      repeat (7) step();
      pipe_pass = 1'b0;
      repeat (20) step();
    end
    check("t1_score3",  score,               32'd3);
    check("t1_ev_cnt3", 32'(ev_count - ev_snap), 32'd3);

    // 2. Second edge inside cooldown is dropped.
    pipe_pass = 1'b1; step();
    pipe_pass = 1'b0; repeat (2) step();
    pipe_pass = 1'b1; step();
    pipe_pass = 1'b0; repeat (10) step();
    check("t2_cooldown", score, 32'd4);

    // 3. Saturation at 99 with no events once saturated.
    ev_snap = ev_count;
    do_passes(105);
    check("t3_sat",       score,                  32'd99);
    check("t3_hi_bits",   {7'd0, score[31:7]},    32'd0);
    check("t3_ev_cnt",    32'(ev_count - ev_snap), 32'd95);
    pipe_pass = 1'b1; step();
    check("t3_sat_ev1",   score_event, 32'd0);
    pipe_pass = 1'b0; step();
    check("t3_sat_ev2",   score_event, 32'd0);
    repeat (4) step();
    check("t3_sat_hold",  score, 32'd99);

    // 4. Phase transitions, ignored inputs, collision beats a pass edge.
    end_game();
    check("t4_over",        game_over, 32'd1);
    check("t4_over_play",   playing,   32'd0);
    check("t4_over_score",  score,     32'd99);
    pulse_start();
    check("t4_idle_over",   game_over, 32'd0);
    check("t4_idle_play",   playing,   32'd0);
    check("t4_idle_score",  score,     32'd99);
    start = 1'b1; collision = 1'b1; step();
    start = 1'b0; collision = 1'b0;
    check("t4_sc_play",     playing,   32'd1);
    check("t4_sc_over",     game_over, 32'd0);
    check("t4_sc_score",    score,     32'd0);
    pulse_start();
    check("t4_start_ign",   playing,   32'd1);
    do_passes(5);
    check("t4_score5",      score,     32'd5);
    ev_snap = ev_count;
    pipe_pass = 1'b1; collision = 1'b1; step();
    pipe_pass = 1'b0; collision = 1'b0;
    check("t4_col_score",   score,     32'd5);
    check("t4_col_over",    game_over, 32'd1);
    do_passes(2);
    check("t4_after_score", score,     32'd5);
    check("t4_after_ev",    32'(ev_count - ev_snap), 32'd0);

    // 5. Mid-game reset at 42.
    pulse_start();
    pulse_start();
    do_passes(42);
    check("t5_score42", score, 32'd42);
    reset = 1'b1; step(); reset = 1'b0;
    check("t5_rst_score", score,     32'd0);
    check("t5_rst_play",  playing,   32'd0);
    check("t5_rst_over",  game_over, 32'd0);
    pulse_start();
    check("t5_restart_play",  playing, 32'd1);
    check("t5_restart_score", score,   32'd0);

`ifdef SCORE_HIGH_EN
    // 6. Best score across games.
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_rst_high", high_score, 32'd0);
    pulse_start();
    do_passes(7);
    end_game();
    check("t6_high7", high_score, 32'd7);
    pulse_start();
    pulse_start();
    check("t6_start_keep", high_score, 32'd7);
    do_passes(4);
    end_game();
    check("t6_high_keep7", high_score, 32'd7);
    pulse_start();
    pulse_start();
    do_passes(12);
    end_game();
    check("t6_high12", high_score, 32'd12);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_high_rst", high_score, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_score_keeper
